// File: rtl/zstr_src_q.sv
// zstr_src_q: z-stream source with delay-tagged data queue and backpressure log.
// Optional timing capture enabled by defining ZSTR_SRC_Q_TMG_EN.
module zstr_src_q #(
    parameter int             BW = 8,
    parameter logic [BW-1:0]  XZ = {BW{1'bx}},
    parameter int             QL = 4,
    parameter int             DW = 8,
    parameter int             TL = 4,
    parameter int             TW = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      put_vld,
    input  logic [BW-1:0]             put_bus,
    input  logic [DW-1:0]             put_dly,
    output logic                      put_rdy,
    output logic                      z_vld,
    output logic [BW-1:0]             z_bus,
    input  logic                      z_rdy,
    output logic                      get_vld,
    output logic [TW-1:0]             get_tmg,
    input  logic                      get_rdy,
    output logic [$clog2(QL+1)-1:0]   q_cnt,
    output logic                      tmg_ovf
);

    localparam int PW = (QL > 1) ? $clog2(QL) : 1;
    localparam int CW = $clog2(QL + 1);

    typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;

    state_t        st;
    logic [BW-1:0] bus_m [QL];
    logic [DW-1:0] dly_m [QL];
    logic [PW-1:0] wp, rp, wp_nx, rp_nx;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dcnt;
    logic          push, xfer, nxt_avail;
    logic [DW-1:0] nxt_dly;

    assign put_rdy   = (cnt < CW'(QL));
    assign push      = put_vld & put_rdy;
    assign z_vld     = (st == VALID);
    assign xfer      = z_vld & z_rdy;
    assign z_bus     = z_vld ? bus_m[rp] : XZ;
    assign q_cnt     = cnt;
    assign wp_nx     = (wp == PW'(QL - 1)) ? '0 : wp + 1'b1;
    assign rp_nx     = (rp == PW'(QL - 1)) ? '0 : rp + 1'b1;
    // Next head is either already queued or arriving in this very cycle.
    assign nxt_avail = (cnt > CW'(1)) | push;
    assign nxt_dly   = (cnt > CW'(1)) ? dly_m[rp_nx] : put_dly;

    // Entry storage; flushing is done through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            bus_m[wp] <= put_bus;
            dly_m[wp] <= put_dly;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp_nx;
            if (xfer) rp <= rp_nx;
            if (push && !xfer)      cnt <= cnt + 1'b1;
            else if (!push && xfer) cnt <= cnt - 1'b1;
        end
    end

    // Head FSM: idle gap countdown, then present until accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st   <= IDLE;
            dcnt <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (push) begin
                        dcnt <= put_dly;
                        st   <= (put_dly == '0) ? VALID : WAIT;
                    end
                end
                WAIT: begin
                    dcnt <= dcnt - 1'b1;
                    if (dcnt == DW'(1)) st <= VALID;
                end
                VALID: begin
                    if (xfer) begin
                        if (nxt_avail) begin
                            dcnt <= nxt_dly;
                            st   <= (nxt_dly == '0) ? VALID : WAIT;
                        end else begin
                            st <= IDLE;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

`ifdef ZSTR_SRC_Q_TMG_EN
    localparam int TPW = (TL > 1) ? $clog2(TL) : 1;
    localparam int TCW = $clog2(TL + 1);

    logic [TW-1:0]  tcnt;
    logic [TW-1:0]  tq [TL];
    logic [TPW-1:0] twp, trp;
    logic [TCW-1:0] tc;
    logic           tpop, tpush, tfull;

    assign get_vld = (tc != '0);
    assign get_tmg = get_vld ? tq[trp] : '0;
    assign tpop    = get_vld & get_rdy;
    assign tfull   = (tc == TCW'(TL));
    assign tpush   = xfer & (!tfull | tpop);

    // Record storage.
    always_ff @(posedge clk) begin
        if (tpush) tq[twp] <= tcnt;
    end

    // Stall counter, record queue control and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt    <= '0;
            twp     <= '0;
            trp     <= '0;
            tc      <= '0;
            tmg_ovf <= 1'b0;
        end else begin
            if (z_vld && !z_rdy) begin
                if (tcnt != '1) tcnt <= tcnt + 1'b1;
            end else begin
                tcnt <= '0;
            end
            if (tpush) twp <= (twp == TPW'(TL - 1)) ? '0 : twp + 1'b1;
            if (tpop)  trp <= (trp == TPW'(TL - 1)) ? '0 : trp + 1'b1;
            if (tpush && !tpop)      tc <= tc + 1'b1;
            else if (!tpush && tpop) tc <= tc - 1'b1;
            if (xfer && tfull && !tpop) tmg_ovf <= 1'b1;
        end
    end
`else
    logic unused_get_rdy;
    assign unused_get_rdy = get_rdy;
    assign get_vld        = 1'b0;
    assign get_tmg        = '0;
    assign tmg_ovf        = 1'b0;
`endif

endmodule

// File: doc/zstr_src_q.md
# zstr_src_q

Parametrised z-stream source for testbenches and traffic generation. It buffers data words pushed through a ready/valid put port, each tagged with a programmable pre-delay. It presents them on a z-stream master port and logs per-transfer backpressure timing into a readable record queue. Successor to the task-driven stream source: handshake-driven on both sides, with insertable idle gaps and bounded, overflow-flagged timing capture.

## Interface
Parameters:
- BW, 8, z-stream bus width
- XZ, {BW{1'bx}}, value driven on z_bus while z_vld is low
- QL, 4, data queue depth (≥1)
- DW, 8, per-entry delay field width
- TL, 4, timing record queue depth (≥1)
- TW, 16, timing record width; counter saturates at 2^TW-1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- put_vld  in  1  data entry offered
- put_bus  in  BW  data word
- put_dly  in  DW  idle cycles to insert before the word is presented
- put_rdy  out  1  data queue can accept (cnt < QL)
- z_vld  out  1  stream transfer valid
- z_bus  out  BW  stream data
- z_rdy  in  1  stream transfer ready
- get_vld  out  1  timing record available
- get_tmg  out  TW  head timing record (0 when empty)
- get_rdy  in  1  pop timing record
- q_cnt  out  $clog2(QL+1)  data queue occupancy
- tmg_ovf  out  1  sticky: a timing record was dropped

## Operation
- Data queue: circular, QL entries of {bus, dly}. Push on put_vld & put_rdy; pop on z transfer (z_vld & z_rdy). No bypass: a write is never presented in the same cycle.
- Head FSM, states IDLE / WAIT / VALID:
  - IDLE: queue empty, z_vld=0. On push: load dly counter with put_dly; go to VALID if 0, else WAIT.
  - WAIT: z_vld=0; decrement counter; go to VALID after exactly dly cycles.
  - VALID: z_vld=1, z_bus = head word. On transfer: if another entry is present, load its dly and go to VALID (dly=0) or WAIT; else go to IDLE.
- z_bus = XZ whenever z_vld=0. Data and z_bus are stable while z_vld=1 and z_rdy=0.
- Timing counter: cleared on entering VALID. Increments each VALID cycle with z_rdy=0 and saturates. On transfer, its current value is pushed to the timing queue. A 0 record means the word was accepted in its first valid cycle.
- Timing queue: circular, TL entries. Pop on get_vld & get_rdy. If the queue is full at a transfer with no pop in that cycle, the record is dropped and tmg_ovf is set. A simultaneous pop frees space, so the record is stored.
- tmg_ovf is cleared only by reset.

## Timing
- Reset (rst=0, asynchronous): both queues flushed, pointers 0, FSM IDLE, counters 0.
- Reset output values: z_vld=0, z_bus=XZ, put_rdy=1, q_cnt=0, get_vld=0, get_tmg=0, tmg_ovf=0.
- Reset mid-transfer discards all pending data and records.
- Latency: a push at edge k with dly=N gives z_vld=1 from cycle k+1+N.
- Back-to-back transfers: when the next entry has dly=0, z_vld stays high across entries.
- Full data queue: put_rdy=0, even in a cycle where a transfer pops an entry. put_rdy rises the cycle after the pop.
- q_cnt and get_vld are registered-state derived; no combinational path from z_rdy or put_vld to put_rdy.
- Empty-queue push while in IDLE and a transfer in the same cycle cannot coincide, because no transfer is possible in IDLE.

## Configuration
- ZSTR_SRC_Q_TMG_EN defined: timing counter, timing queue and tmg_ovf are implemented as described.
- Not defined: timing logic is omitted. get_vld=0, get_tmg=0 and tmg_ovf=0 constantly, and get_rdy is ignored. Data path and FSM are unchanged.

## Test plan
- Reset, then push 0xA5 with dly=0 while z_rdy=1. Required: z_vld high the cycle after the push with z_bus=0xA5; one transfer; timing record 0; z_bus=XZ afterwards.
- Push 0x11 with dly=3 into an empty queue. Required: z_vld low for exactly 3 cycles, then high.
- Push QL=4 words with dly=0 while z_rdy=0. Required: put_rdy=0, q_cnt=4. Raise z_rdy for one cycle: put_rdy returns to 1 the next cycle, and words leave in push order.
- Hold z_rdy low for 5 valid cycles, then high. Required: get_tmg=5. With TW=2, the same stimulus yields 3 (saturation).
- Perform TL+1=5 transfers with get_rdy=0. Required: 4 records kept and tmg_ovf=1. Repeat with a pop coinciding with the 5th transfer: tmg_ovf stays 0.
- Assert rst while z_vld=1 with 2 entries queued. Required: z_vld=0, q_cnt=0 and get_vld=0 immediately. After release, the old data never appears.
